// File: rtl/sha_mem_responder.sv
// Backing RAM and run sequencer for simplified_sha256: the host owns the port in IDLE, the hasher from START through FLUSH.
// `define SHA_MEM_ACCESS_CNT_EN adds saturating rd_cnt/wr_cnt counters of hasher RUN-cycle accesses.
module sha_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  input  logic        run_req,
  output logic        start,
  input  logic        done,
  output logic        busy,
  output logic        run_done,
  output logic        timeout
`ifdef SHA_MEM_ACCESS_CNT_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, START, RUN, FLUSH} state_e;

  state_e              state_q;
  logic                start_q, busy_q, run_done_q, timeout_q, host_gnt_q;
  logic [31:0]         tcnt_q;
  logic [2:0]          fcnt_q;
  logic [READ_LAT-1:0] hv_q;
  logic [31:0]         hd_q [READ_LAT];
  logic [31:0]         md_q [READ_LAT];
  logic [31:0]         ram_q [DEPTH];

  logic        host_own, acc_we, in_range, rd_host, rd_hash;
  logic [15:0] acc_addr;
  logic [31:0] acc_wdat, ram_rd;

  // Only the current owner's port reaches the RAM; the other side is simply not looked at.
  assign host_own = (state_q == IDLE);
  assign acc_addr = host_own ? host_addr : mem_addr;
  assign acc_wdat = host_own ? host_wdata : mem_write_data;
  assign acc_we   = host_own ? (host_req & host_we) : mem_we;
  assign rd_host  = host_own & host_req & ~host_we;
  assign rd_hash  = ~host_own;
  assign in_range = ({1'b0, acc_addr} < 17'(DEPTH));
  assign ram_rd   = in_range ? ram_q[acc_addr[AW-1:0]] : 32'h0;

  always_ff @(posedge clk) begin
    if (acc_we && in_range) ram_q[acc_addr[AW-1:0]] <= acc_wdat;
  end

  // Stage 0 holds its last sample between reads, so the output keeps the last returned word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hv_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        hd_q[i] <= '0;
        md_q[i] <= '0;
      end
    end else begin
      hv_q[0] <= rd_host;
      hd_q[0] <= rd_host ? ram_rd : hd_q[0];
      md_q[0] <= rd_hash ? ram_rd : md_q[0];
      for (int i = 1; i < READ_LAT; i++) begin
        hv_q[i] <= hv_q[i-1];
        hd_q[i] <= hd_q[i-1];
        md_q[i] <= md_q[i-1];
      end
    end
  end

`ifdef SHA_MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      run_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      host_gnt_q <= 1'b0;
      tcnt_q     <= '0;
      fcnt_q     <= '0;
`ifdef SHA_MEM_ACCESS_CNT_EN
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
`endif
    end else begin
      start_q    <= 1'b0;
      run_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          host_gnt_q <= ~run_req;
          if (run_req) begin
            state_q   <= START;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
`ifdef SHA_MEM_ACCESS_CNT_EN
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
`endif
          end
        end
        START: state_q <= RUN;
        RUN: begin
`ifdef SHA_MEM_ACCESS_CNT_EN
          if (mem_we) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
          end else if (rd_cnt_q != 16'hFFFF) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
          end
`endif
          if (done) begin
            state_q <= FLUSH;
            fcnt_q  <= '0;
          end else if ((TIMEOUT_CYC != 0) && (tcnt_q == 32'(TIMEOUT_CYC - 1))) begin
            state_q   <= FLUSH;
            fcnt_q    <= '0;
            timeout_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end
        FLUSH: begin
          // Hold until every read sampled in RUN has left the pipeline.
          if (fcnt_q == 3'(READ_LAT - 1)) begin
            state_q    <= IDLE;
            run_done_q <= 1'b1;
            busy_q     <= 1'b0;
            host_gnt_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start         = start_q;
  assign busy          = busy_q;
  assign run_done      = run_done_q;
  assign timeout       = timeout_q;
  assign host_gnt      = host_gnt_q;
  assign host_rvalid   = hv_q[READ_LAT-1];
  assign host_rdata    = hd_q[READ_LAT-1];
  assign mem_read_data = md_q[READ_LAT-1];
`ifdef SHA_MEM_ACCESS_CNT_EN
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;
`endif

endmodule

// File: doc/sha_mem_responder.md
Name: sha_mem_responder

Overview:
- Word-addressed memory responder serving the far end of the hasher's memory port (`mem_we`/`mem_addr`/`mem_write_data` in, `mem_read_data` out).
- A host port loads the message and reads back the digest while the hasher is idle.
- An internal sequencer pulses `start`, hands the port to the hasher, waits for `done`, drains in-flight reads, then returns the port to the host.
- Sits between the bench/system host and `simplified_sha256` as its backing store and run controller.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 16..65536.
- READ_LAT, 1, cycles from address sample to `mem_read_data`/`host_rdata` update; legal range 1..4.
- TIMEOUT_CYC, 0, maximum RUN cycles before forced abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic and the RAM are on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_we  in  1  hasher write enable.
- mem_addr  in  16  hasher word address.
- mem_write_data  in  32  hasher write data.
- mem_read_data  out  32  read data to the hasher.
- host_req  in  1  host access request, one word per cycle.
- host_we  in  1  host write (1) or read (0), qualified by host_req.
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_gnt  out  1  host owns the memory port.
- host_rdata  out  32  host read data.
- host_rvalid  out  1  one-cycle pulse marking host_rdata valid.
- run_req  in  1  request a hash run.
- start  out  1  one-cycle start pulse to the hasher.
- done  in  1  hasher completion.
- busy  out  1  high from START through FLUSH.
- run_done  out  1  one-cycle completion pulse.
- timeout  out  1  sticky: the last run was aborted.

Behaviour:
- States: IDLE, START, RUN, FLUSH. Reset enters IDLE.
- Reset values: start=0, busy=0, run_done=0, timeout=0, host_gnt=0, host_rvalid=0, mem_read_data=0, host_rdata=0, all read pipeline stages cleared.
- RAM contents are not reset.
- All outputs are registered. host_gnt goes to 1 on the first clock after reset release.
- Port ownership:
  - Host owns the port when state==IDLE; the hasher owns it in START, RUN and FLUSH.
  - Accesses from the non-owner are ignored: no write, no read response, no queuing.
- IDLE:
  - host_req&host_we writes RAM at the edge.
  - host_req&!host_we returns host_rdata with host_rvalid=1 exactly READ_LAT cycles later.
  - run_req -> START. host_gnt drops on the same edge; any host request in that cycle is still served.
- START: start=1 for this one cycle, busy=1, timeout cleared, timeout counter cleared; next state is RUN. A done seen in START is ignored.
- RUN: the hasher port is live every cycle.
  - mem_we=1 writes mem_write_data at the edge.
  - Every cycle is a read. mem_read_data reflects RAM[mem_addr] sampled READ_LAT cycles earlier, updated every cycle.
  - done=1 -> FLUSH.
  - If TIMEOUT_CYC!=0 and the RUN cycle count reaches TIMEOUT_CYC, set timeout=1 and go to FLUSH.
- FLUSH: hold for READ_LAT cycles so pending reads complete; hasher writes are still accepted. Then pulse run_done=1 for one cycle, busy=0, and return to IDLE.
- Read/write to the same address in the same cycle: read returns the old data (read-before-write).
- Address range: index = addr mod 2^16. Index >= DEPTH drops writes and returns 32'h0 for reads, on both ports.
- run_req outside IDLE is ignored. done outside RUN is ignored.
- reset_n low mid-run: immediate return to IDLE, pipeline flushed, no run_done pulse, RAM keeps its partial contents.

Optional Feature:
- Macro: SHA_MEM_ACCESS_CNT_EN.
- Defined:
  - Adds outputs rd_cnt[15:0] and wr_cnt[15:0].
  - In RUN, rd_cnt counts cycles where mem_we=0; wr_cnt counts cycles where mem_we=1. Both saturate at 16'hFFFF.
  - Both clear in START and on reset, and hold their values through FLUSH/IDLE.
- Not defined: no counter ports or logic; all other behaviour is identical.

Test Plan:
- Host writes 32'hDEADBEEF @5, then reads @5 with READ_LAT=1 -> host_rvalid one cycle after the read request, host_rdata=32'hDEADBEEF. Repeat with READ_LAT=3 -> data three cycles after the request.
- Load 16 message words @0..15, pulse run_req -> start high exactly 1 cycle, host_gnt=0. Hasher reads @0 -> mem_read_data = word0 after READ_LAT. Hasher writes 8 words @16..23, then asserts done -> run_done after READ_LAT FLUSH cycles; host reads back 8 matching words.
- Host read @300 with DEPTH=256 -> host_rdata=0. Hasher write @300 -> no RAM location changes.
- Host write issued during RUN -> ignored, RAM unchanged, no host_rvalid. run_req during RUN -> no second start pulse.
- TIMEOUT_CYC=50, done never asserted -> timeout=1 after 50 RUN cycles, run_done pulses. Next run_req clears timeout in START.
- reset_n low 3 cycles into RUN -> IDLE, busy=0, no run_done pulse. Data written before reset is still readable. With SHA_MEM_ACCESS_CNT_EN, 10 reads + 2 writes in a run -> rd_cnt=10, wr_cnt=2.
